// File: rtl/proto_stream_arbiter_if.sv
// Bundle of signals between the stream arbiter, its requesters and the protobuf deserializer.
// The master side is the arbiter; the slave side is the requesters plus the downstream deserializer.
interface proto_stream_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = $clog2(NUM_REQ)
);
    logic [NUM_REQ*8-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [7:0]           protoStream_o;
    logic                 protoStream_valid_o;
    logic                 protoStream_ready_i;
    logic                 msg_start_o;
    logic                 msg_last_o;
    logic [GRANT_W-1:0]   grant_o;
    logic                 grant_valid_o;
    logic                 len_err_o;
    logic [NUM_REQ-1:0]   err_mask_o;

    modport master (
        input  req_data_i,
        input  req_valid_i,
        input  protoStream_ready_i,
        output req_ready_o,
        output protoStream_o,
        output protoStream_valid_o,
        output msg_start_o,
        output msg_last_o,
        output grant_o,
        output grant_valid_o,
        output len_err_o,
        output err_mask_o
    );

    modport slave (
        output req_data_i,
        output req_valid_i,
        output protoStream_ready_i,
        input  req_ready_o,
        input  protoStream_o,
        input  protoStream_valid_o,
        input  msg_start_o,
        input  msg_last_o,
        input  grant_o,
        input  grant_valid_o,
        input  len_err_o,
        input  err_mask_o
    );
endinterface

// File: rtl/proto_stream_arbiter.sv
// Round-robin arbiter feeding one protobuf deserializer from several length-prefixed byte streams.
// The varint length prefix is consumed here; only framed payload bytes go downstream.
module proto_stream_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int LEN_W         = 16,
    parameter int MAX_LEN_BYTES = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    proto_stream_arbiter_if.master bus
);
    localparam int GRANT_W = $clog2(NUM_REQ);
    localparam int ACC_W   = 7 * MAX_LEN_BYTES;
    localparam int K_W     = (MAX_LEN_BYTES > 1) ? $clog2(MAX_LEN_BYTES) : 1;

    localparam logic [1:0] ST_ARB     = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_ERR     = 2'd3;

    logic [1:0]         state_reg,         state_next;
    logic [GRANT_W-1:0] grant_reg,         grant_next;
    logic [GRANT_W-1:0] rr_ptr_reg,        rr_ptr_next;
    logic [ACC_W-1:0]   len_acc_reg,       len_acc_next;
    logic [K_W-1:0]     k_reg,             k_next;
    logic [LEN_W-1:0]   remaining_reg,     remaining_next;
    logic               first_pending_reg, first_pending_next;
    logic [NUM_REQ-1:0] err_mask_reg,      err_mask_next;

    logic [7:0]         req_byte [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [7:0]         owner_byte;
    logic               owner_valid;
    logic               in_len;
    logic               in_payload;
    logic               xfer;
    logic [GRANT_W-1:0] grant_succ;
    logic [ACC_W-1:0]   acc_shifted;
    logic               acc_ovf;
    logic               len_error;
    logic               arb_found;
    logic [GRANT_W-1:0] arb_idx;
    logic [GRANT_W-1:0] arb_cand;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_byte[gi] = bus.req_data_i[gi*8 +: 8];
            assign eligible[gi] = bus.req_valid_i[gi] & ~err_mask_reg[gi];
            // Only the owner ever sees ready: always in LEN, gated by downstream in PAYLOAD.
            assign bus.req_ready_o[gi] = (grant_reg == GRANT_W'(gi)) &
                                         (in_len | (in_payload & bus.protoStream_ready_i));
        end
    endgenerate

    assign owner_byte  = req_byte[grant_reg];
    assign owner_valid = bus.req_valid_i[grant_reg];
    assign in_len      = (state_reg == ST_LEN);
    assign in_payload  = (state_reg == ST_PAYLOAD);
    assign xfer        = in_payload & owner_valid & bus.protoStream_ready_i;
    assign grant_succ  = (grant_reg == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_reg + GRANT_W'(1);

    // Each prefix byte lands in its own 7-bit slot; slots above k are still zero, so this is an OR-in.
    generate
        for (gi = 0; gi < MAX_LEN_BYTES; gi++) begin : g_acc
            assign acc_shifted[gi*7 +: 7] = (k_reg == K_W'(gi)) ? owner_byte[6:0]
                                                                  : len_acc_reg[gi*7 +: 7];
        end
        if (ACC_W > LEN_W) begin : g_ovf
            assign acc_ovf = |acc_shifted[ACC_W-1:LEN_W];
        end else begin : g_no_ovf
            assign acc_ovf = 1'b0;
        end
    endgenerate

    assign len_error = (owner_byte[7] & (k_reg == K_W'(MAX_LEN_BYTES - 1))) | acc_ovf;

    // First eligible index at or after the round-robin pointer, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_ptr_reg;
        arb_cand  = rr_ptr_reg;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_cand = GRANT_W'((int'(rr_ptr_reg) + i) % NUM_REQ);
            if (!arb_found && eligible[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        grant_next         = grant_reg;
        rr_ptr_next        = rr_ptr_reg;
        len_acc_next       = len_acc_reg;
        k_next             = k_reg;
        remaining_next     = remaining_reg;
        first_pending_next = first_pending_reg;
        err_mask_next      = err_mask_reg;
        case (state_reg)
            ST_ARB: begin
                if (arb_found) begin
                    grant_next   = arb_idx;
                    len_acc_next = '0;
                    k_next       = '0;
                    state_next   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (owner_valid) begin
                    len_acc_next = acc_shifted;
                    k_next       = k_reg + K_W'(1);
                    if (len_error) begin
                        err_mask_next[grant_reg] = 1'b1;
                        state_next               = ST_ERR;
                    end else if (!owner_byte[7]) begin
                        if (acc_shifted == '0) begin
                            // Empty message: nothing to forward, just hand the turn on.
                            rr_ptr_next = grant_succ;
                            state_next  = ST_ARB;
                        end else begin
                            remaining_next     = acc_shifted[LEN_W-1:0];
                            first_pending_next = 1'b1;
                            state_next         = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    remaining_next     = remaining_reg - LEN_W'(1);
                    first_pending_next = 1'b0;
                    if (remaining_reg == LEN_W'(1)) begin
                        rr_ptr_next = grant_succ;
                        state_next  = ST_ARB;
                    end
                end
            end
            default: begin
                state_next = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_reg         <= ST_ARB;
            grant_reg         <= '0;
            rr_ptr_reg        <= '0;
            len_acc_reg       <= '0;
            k_reg             <= '0;
            remaining_reg     <= '0;
            first_pending_reg <= 1'b0;
            err_mask_reg      <= '0;
        end else begin
            state_reg         <= state_next;
            grant_reg         <= grant_next;
            rr_ptr_reg        <= rr_ptr_next;
            len_acc_reg       <= len_acc_next;
            k_reg             <= k_next;
            remaining_reg     <= remaining_next;
            first_pending_reg <= first_pending_next;
            err_mask_reg      <= err_mask_next;
        end
    end

    assign bus.protoStream_o       = in_payload ? owner_byte : 8'h00;
    assign bus.protoStream_valid_o = in_payload & owner_valid;
    assign bus.msg_start_o         = in_payload & owner_valid & first_pending_reg;
    assign bus.msg_last_o          = in_payload & owner_valid & (remaining_reg == LEN_W'(1));
    assign bus.grant_o             = grant_reg;
    assign bus.grant_valid_o       = in_len | in_payload;
    assign bus.len_err_o           = (state_reg == ST_ERR);
    assign bus.err_mask_o          = err_mask_reg;
endmodule
